// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one two-stage registered adder among NREQ clients, with grant
// locking for multi-word carry chains. Define ADDARB_OVF_EN to add the rsp_ovf output.
module adder_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int ADD_LAT = 2,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_last,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic [W-1:0]      add_sum,
    input  logic              add_cout,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_last,
`ifdef ADDARB_OVF_EN
    output logic              rsp_ovf,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WAIT_C, CHAIN} state_t;

    state_t          state, state_nx;
    logic [IDW-1:0]  rr_ptr, owner, sel, scan_idx;
    logic            carry_q, accept, sel_last, sel_cin, link_hit;
    logic [NREQ-1:0] grant;
    logic [W-1:0]    a_arr [NREQ];
    logic [W-1:0]    b_arr [NREQ];

    logic [ADD_LAT:0] vld_p, last_p, link_p;
    logic [IDW-1:0]   id_p [ADD_LAT+1];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[i*W +: W];
            b_arr[i] = req_b[i*W +: W];
        end
    end

    // Grant: in IDLE the lowest offset from rr_ptr wins; in CHAIN only the owner may issue.
    always_comb begin
        grant    = '0;
        sel      = '0;
        scan_idx = '0;
        case (state)
            IDLE: begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    scan_idx = IDW'((int'(rr_ptr) + k) % NREQ);
                    if (req_valid[scan_idx]) sel = scan_idx;
                end
                grant[sel] = |req_valid;
            end
            CHAIN: begin
                sel          = owner;
                grant[owner] = req_valid[owner];
            end
            default: ;
        endcase
        if (rst) grant = '0;
    end

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign sel_last  = req_last[sel];
    assign sel_cin   = (state == CHAIN) ? carry_q : req_cin[sel];

    assign rsp_valid = vld_p[ADD_LAT];
    assign rsp_id    = id_p[ADD_LAT];
    assign rsp_last  = last_p[ADD_LAT];
    assign rsp_sum   = add_sum;
    assign rsp_cout  = add_cout;
    assign busy      = !rst && ((state != IDLE) || (|vld_p));

    // Only the tagged chained word of the owner releases WAIT_C, never an earlier IDLE word.
    assign link_hit = (state == WAIT_C) && rsp_valid && link_p[ADD_LAT] && (rsp_id == owner);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && !sel_last) state_nx = WAIT_C;
            WAIT_C:  if (link_hit) state_nx = CHAIN;
            CHAIN:   if (accept) state_nx = sel_last ? IDLE : WAIT_C;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            carry_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && accept && !sel_last) owner <= sel;
            if (link_hit) carry_q <= add_cout;
            if (accept && sel_last) rr_ptr <= IDW'((int'(sel) + 1) % NREQ);
        end
    end

    // Issue stage p0 then ADD_LAT shift stages tracking the word through the adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
            vld_p   <= '0;
            last_p  <= '0;
            link_p  <= '0;
            for (int k = 0; k <= ADD_LAT; k++) id_p[k] <= '0;
        end else begin
            if (accept) begin
                add_a   <= a_arr[sel];
                add_b   <= b_arr[sel];
                add_cin <= sel_cin;
            end
            vld_p   <= {vld_p[ADD_LAT-1:0], accept};
            last_p  <= {last_p[ADD_LAT-1:0], accept & sel_last};
            link_p  <= {link_p[ADD_LAT-1:0], accept & ~sel_last};
            id_p[0] <= sel;
            for (int k = 1; k <= ADD_LAT; k++) id_p[k] <= id_p[k-1];
        end
    end

`ifdef ADDARB_OVF_EN
    logic [ADD_LAT:0] amsb_p, bmsb_p;

    function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            amsb_p <= '0;
            bmsb_p <= '0;
        end else begin
            amsb_p <= {amsb_p[ADD_LAT-1:0], a_arr[sel][W-1]};
            bmsb_p <= {bmsb_p[ADD_LAT-1:0], b_arr[sel][W-1]};
        end
    end

    assign rsp_ovf = rsp_valid && rsp_last && ovf_of(amsb_p[ADD_LAT], bmsb_p[ADD_LAT], add_sum[W-1]);
`endif

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one registered 16-bit adder (two-stage: input register, then output register) among NREQ requesters.
- Round-robin arbitration; one operation issued per cycle.
- Multi-word (multi-precision) adds chain the carry between words by locking the grant to one requester.
- Sits between client engines and the adder; drives the adder's operand/carry inputs and tags returning sums with the requester id.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 16, operand width; matches adder width
- ADD_LAT, 2, clock edges from add_a/add_b/add_cin valid to add_sum/add_cout valid
- IDW, 2, requester id width, equal to clog2(NREQ)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_a  in  NREQ*W  operand A, requester i at [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_cin  in  NREQ  carry-in; used only on the first word of an operation
- req_last  in  NREQ  1 = final (or only) word of an operation
- add_a  out  W  registered operand A to adder
- add_b  out  W  registered operand B to adder
- add_cin  out  1  registered carry-in to adder
- add_sum  in  W  adder sum
- add_cout  in  1  adder carry-out
- rsp_valid  out  1  result valid for one cycle; no backpressure
- rsp_id  out  IDW  requester that issued the word
- rsp_sum  out  W  pass-through of add_sum
- rsp_cout  out  1  pass-through of add_cout
- rsp_last  out  1  word is last of its operation
- busy  out  1  state != IDLE, or any word in flight

Behaviour:
- Accept: a word is accepted on a clock edge where req_valid[i] && req_ready[i].
  - add_a/add_b/add_cin register the selected operands on that edge (accept edge E).
  - With no accept, they hold their values.
- Latency:
  - rsp_valid/rsp_id/rsp_last come from an ADD_LAT-deep valid/id/last shift register.
  - They are high in the cycle after edge E+ADD_LAT; rsp_sum/rsp_cout are sampled in that same cycle.
  - Full throughput: one word per cycle in IDLE.
- Arbitration in IDLE:
  - req_ready = one-hot grant to the first valid requester at or after rr_ptr, wrapping modulo NREQ.
  - req_ready is combinational from req_valid and state.
- rr_ptr: after the last word of an operation is accepted from requester i, rr_ptr <= (i+1) mod NREQ.
- States:
  - IDLE: arbitrate.
    - Accept with req_last=1 -> stay IDLE.
    - Accept with req_last=0 -> latch owner=i, go to WAIT_C.
  - WAIT_C: req_ready all 0.
    - When a response with rsp_id==owner is valid, capture carry_q <= rsp_cout and go to CHAIN.
  - CHAIN: req_ready = owner bit only, gated by req_valid[owner].
    - add_cin <= carry_q; req_cin is ignored.
    - Accept with req_last=1 -> IDLE and update rr_ptr.
    - Accept with req_last=0 -> WAIT_C.
    - Owner holds valid low -> remain in CHAIN indefinitely; other requesters stay blocked.
- Words issued in IDLE before a chained word still drain normally.
  - WAIT_C matches on owner and the in-flight position of the chained word, not on the first response seen.
- Simultaneous events: a response arriving in the same cycle as an accept is handled independently; no collision, since latency is fixed.
- Sums wrap modulo 2^W. Carry is reported only through rsp_cout.
- Reset (any cycle, including mid-chain):
  - state=IDLE, rr_ptr=0, owner=0, carry_q=0.
  - Shift register cleared: no response is emitted for words in flight.
  - add_a=0, add_b=0, add_cin=0, req_ready=0 during reset, rsp_valid=0, rsp_id=0, rsp_last=0, busy=0.
  - The chained operation is aborted; the requester must reissue it from the first word.

Optional Feature:
- Macro ADDARB_OVF_EN.
- Defined:
  - Adds output rsp_ovf (1 bit), the signed overflow of a last word: (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
  - Operand MSBs are carried through the shift register.
  - rsp_ovf is 0 for non-last words, 0 when rsp_valid=0, and 0 on reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Single op: req0 a=0x1234 b=0x0F0F cin=1 last=1 -> rsp_valid ADD_LAT cycles after accept, id=0, sum=0x2144, cout=0, last=1.
- Round-robin: all four requesters valid every cycle with last=1 -> grants in order 0,1,2,3,0,1...; four rsp in the same order, one per cycle, no bubbles.
- 32-bit chain on req2:
  - Word 1: a=0xFFFF b=0x0001 cin=0 last=0 -> rsp sum=0x0000 cout=1; req_ready stays 0 until cout returns.
  - Word 2: a=0x0000 b=0x0000 last=1 -> add_cin=1, sum=0x0001, cout=0.
  - Other requesters are blocked throughout the chain.
- Wrap: a=0xFFFF b=0xFFFF cin=1 -> sum=0xFFFF cout=1; with ADDARB_OVF_EN, a=0x7FFF b=0x0001 -> sum=0x8000 ovf=1.
- Reset mid-chain: assert rst in CHAIN with two words in flight -> no rsp afterwards, busy=0, rr_ptr=0, and the next grant goes to the lowest valid requester.
